// File: rtl/fact_pkg.sv
// Shared definitions for the memory-mapped factorial accelerator.
// Address constants for the four registers, the core FSM state
// encoding and the bit positions in the status register.
package fact_pkg;

  localparam logic [1:0] ADDR_N    = 2'd0;
  localparam logic [1:0] ADDR_GO   = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_RES  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam int DONE_BIT = 0;
  localparam int BUSY_BIT = 1;
  localparam int ERR_BIT  = 2;

endpackage

// File: rtl/fact_core.sv
// Iterative factorial engine: one multiply per clock, counting n down.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   start     request a new run; taken only when not computing
//   n         operand, captured on the edge a start is taken
//   result    final (or overflow-truncated) product, valid with done
//   done      one-cycle pulse on the cycle after the run finishes
//   err       qualifies done: the run stopped on overflow
//   busy      high while in MULT
module fact_core
  import fact_pkg::*;
#(
  parameter int N_W   = 4,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  output logic [RES_W-1:0] result,
  output logic             done,
  output logic             err,
  output logic             busy
);

  stateT              state, stateNext;
  logic [RES_W-1:0]   product, productNext;
  logic [N_W-1:0]     cnt, cntNext;
  logic [RES_W-1:0]   resultNext;
  logic               doneNext, errNext;
  logic [2*RES_W-1:0] full;

  // Full-width product so overflow past RES_W can be detected exactly.
  assign full = {{RES_W{1'b0}}, product} * {{(2*RES_W-N_W){1'b0}}, cnt};
  assign busy = (state == MULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      product <= '0;
      cnt     <= '0;
      result  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= stateNext;
      product <= productNext;
      cnt     <= cntNext;
      result  <= resultNext;
      done    <= doneNext;
      err     <= errNext;
    end
  end

  always_comb begin
    stateNext   = state;
    productNext = product;
    cntNext     = cnt;
    resultNext  = result;
    doneNext    = 1'b0;
    errNext     = err;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          productNext = RES_W'(1);
          cntNext     = n;
          errNext     = 1'b0;
          stateNext   = MULT;
        end
      end
      MULT: begin
        if (cnt > N_W'(1)) begin
          if (full[2*RES_W-1:RES_W] != '0) begin
            errNext    = 1'b1;
            resultNext = full[RES_W-1:0];
            doneNext   = 1'b1;
            stateNext  = DONE;
          end else begin
            productNext = full[RES_W-1:0];
            cntNext     = cnt - N_W'(1);
          end
        end else begin
          // n of 0 or 1 lands here immediately with product still 1.
          resultNext = product;
          doneNext   = 1'b1;
          stateNext  = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: rtl/fact_accel_mmio.sv
// Memory-mapped factorial accelerator on the word-addressed peripheral bus.
// Registers: 0 N (rw), 1 Go (rw, bit 0), 2 status {Err,Busy,Done} (ro),
// 3 Result (ro). A Go write with bit 0 set starts a run unless one is
// already in progress.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   A, WE, WD register address, write enable, write data
//   RD        combinational read data for address A
//   busy      high while the core is computing
//   irq       level copy of the status Done bit
module fact_accel_mmio
  import fact_pkg::*;
#(
  parameter int N_W    = 4,
  parameter int RES_W  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        A,
  input  logic              WE,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD,
  output logic              busy,
  output logic              irq
);

  logic [N_W-1:0]   nReg;
  logic             goReg, doneReg, errReg;
  logic [RES_W-1:0] resReg;
  logic             start, accept;
  logic [RES_W-1:0] coreResult;
  logic             coreDone, coreErr, coreBusy;
  logic             unusedWdBits;

  assign unusedWdBits = ^WD;

  assign start  = WE && (A == ADDR_GO) && WD[0];
  assign accept = start && !coreBusy;

  fact_core #(.N_W(N_W), .RES_W(RES_W)) uCore (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n      (nReg),
    .result (coreResult),
    .done   (coreDone),
    .err    (coreErr),
    .busy   (coreBusy)
  );

  // Result/Done/Err land here one edge after the core finishes, so a run
  // of n>=1 shows Done n+1 edges after the accepting Go.
  always_ff @(posedge clk) begin
    if (rst) begin
      nReg    <= '0;
      goReg   <= 1'b0;
      doneReg <= 1'b0;
      errReg  <= 1'b0;
      resReg  <= '0;
    end else begin
      if (WE && (A == ADDR_N))  nReg  <= WD[N_W-1:0];
      if (WE && (A == ADDR_GO)) goReg <= WD[0];
      if (coreDone) begin
        resReg  <= coreResult;
        doneReg <= 1'b1;
        errReg  <= coreErr;
      end
      // A freshly accepted Go clears the sticky flags, even on the same edge.
      if (accept) begin
        doneReg <= 1'b0;
        errReg  <= 1'b0;
      end
    end
  end

  always_comb begin
    RD = '0;
    case (A)
      ADDR_N:  RD[N_W-1:0] = nReg;
      ADDR_GO: RD[0] = goReg;
      ADDR_STAT: begin
        RD[DONE_BIT] = doneReg;
        RD[BUSY_BIT] = coreBusy;
        RD[ERR_BIT]  = errReg;
      end
      default: RD[RES_W-1:0] = resReg;
    endcase
  end

  assign busy = coreBusy;
  assign irq  = doneReg;

endmodule

// File: tb/tb_fact_accel_mmio.sv
module tb_fact_accel_mmio;

  logic        clk, rst, WE, busy, irq;
  logic [1:0]  A;
  logic [31:0] WD, RD;

  fact_accel_mmio #(.N_W(4), .RES_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .A(A), .WE(WE), .WD(WD), .RD(RD), .busy(busy), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Reference: k = edges the engine spends computing, result, overflow flag.
  function automatic void factModel(input int n, output int k, output logic [31:0] res,
                                    output logic e);
    logic [63:0] p, full;
    p = 64'd1; k = 0; e = 1'b0; res = 32'd0;
    for (int c = n; c >= 2; c--) begin
      k++;
      full = p * 64'(c);
      if (full[63:32] != 32'd0) begin
        e = 1'b1;
        res = full[31:0];
        return;
      end
      p = full;
    end
    k++;
    res = p[31:0];
  endfunction

  // Behavioural model of the visible registers.
  logic        modelOn = 1'b0;
  logic [3:0]  mN;
  logic        mGo, mDone, mErr, mRun, mRunErr, mBusy;
  logic [31:0] mRes, mRunRes;
  int          mK, mEdges;

  initial begin
    logic       acc;
    logic [3:0] nOld;
    forever begin
      @(posedge clk);
      if (rst) begin
        mN = 0; mGo = 0; mDone = 0; mErr = 0; mRes = 0; mRun = 0; mRunErr = 0;
        mRunRes = 0; mK = 0; mEdges = 0; modelOn = 1'b1;
      end else if (modelOn) begin
        acc  = WE && (A == 2'd1) && WD[0] && !mBusy;
        nOld = mN;
        if (mRun) begin
          mEdges++;
          if (mEdges == mK + 1) begin
            mDone = 1; mErr = mRunErr; mRes = mRunRes; mRun = 0;
          end
        end
        if (WE && A == 2'd0) mN = WD[3:0];
        if (WE && A == 2'd1) mGo = WD[0];
        if (acc) begin
          factModel(int'(nOld), mK, mRunRes, mRunErr);
          mRun = 1; mEdges = 0; mDone = 0; mErr = 0;
        end
      end
      mBusy = mRun && (mEdges < mK);
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic [31:0] expRd;
    forever begin
      @(negedge clk);
      if (modelOn) begin
        case (A)
          2'd0:    expRd = {28'd0, mN};
          2'd1:    expRd = {31'd0, mGo};
          2'd2:    expRd = {29'd0, mErr, mBusy, mDone};
          default: expRd = mRes;
        endcase
        chk("rd_model", RD, expRd);
        chk("busy_model", {31'd0, busy}, {31'd0, mBusy});
        chk("irq_model", {31'd0, irq}, {31'd0, mDone});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    A = a; WE = 1'b1; WD = d;
    step();
    WE = 1'b0;
  endtask

  task automatic rdChk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    A = a;
    #1;
    chk(nm, RD, exp);
  endtask

  // Waits for irq, counting edges and busy samples; lat/bc carry on from caller.
  task automatic waitDone(inout int lat, inout int bc);
    while (!irq && lat < 60) begin
      A = 2'($urandom_range(0, 3));
      step();
      lat++;
      bc += int'(busy);
    end
    chk("done_timeout", {31'd0, irq}, 32'd1);
  endtask

  task automatic runFact(input logic [3:0] n, output int lat, output int bc);
    wr(2'd0, {28'd0, n});
    wr(2'd1, 32'd1);
    lat = 0;
    bc  = int'(busy);
    waitDone(lat, bc);
  endtask

  initial begin
    int          lat, bc, k, nI;
    logic [31:0] res;
    logic        e;
    logic [3:0]  n;
    rst = 1'b1; WE = 1'b0; A = 2'd0; WD = 32'd0;
    repeat (2) step();
    rst = 1'b0;

    for (int a = 0; a < 4; a++) rdChk("reset_rd", 2'(a), 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);

    // Pin the reference function with hand-computed values.
    factModel(5, k, res, e);
    chk("model_5", res, 32'd120);
    factModel(13, k, res, e);
    chk("model_13", {res[30:0], e}, {31'd1932053504, 1'b1});

    runFact(4'd5, lat, bc);
    chk("lat_5", lat, 32'd6);
    chk("busy_cycles_5", bc, 32'd5);
    rdChk("res_5", 2'd3, 32'd120);
    rdChk("stat_5", 2'd2, 32'b001);
    chk("irq_5", {31'd0, irq}, 32'd1);

    runFact(4'd0, lat, bc);
    chk("lat_0", lat, 32'd2);
    rdChk("res_0", 2'd3, 32'd1);
    rdChk("stat_0", 2'd2, 32'b001);

    runFact(4'd12, lat, bc);
    rdChk("res_12", 2'd3, 32'h1C8CFC00);
    rdChk("stat_12", 2'd2, 32'b001);

    runFact(4'd13, lat, bc);
    rdChk("stat_13", 2'd2, 32'b101);
    rdChk("res_13", 2'd3, 32'd1932053504);
    chk("busy_13", {31'd0, busy}, 32'd0);

    // Go while busy is ignored; N write while busy only updates N.
    wr(2'd0, 32'd6);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'd3);
    wr(2'd1, 32'd1);
    lat = 2; bc = 0;
    waitDone(lat, bc);
    chk("lat_6", lat, 32'd7);
    rdChk("res_6", 2'd3, 32'd720);
    rdChk("n_rb", 2'd0, 32'd3);
    rdChk("go_rb", 2'd1, 32'd1);
    wr(2'd1, 32'd1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rdChk("stat_run", 2'd2, 32'b010);
    lat = 0; bc = 0;
    waitDone(lat, bc);
    rdChk("res_3", 2'd3, 32'd6);

    // Reset in the middle of a run.
    wr(2'd0, 32'd10);
    wr(2'd1, 32'd1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) rdChk("midrst_rd", 2'(a), 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    runFact(4'd4, lat, bc);
    rdChk("res_4", 2'd3, 32'd24);

    // Random runs with random register traffic while busy.
    for (int it = 0; it < 40; it++) begin
      n = 4'($urandom_range(0, 15));
      factModel(int'(n), k, res, e);
      wr(2'd0, {28'd0, n});
      wr(2'd1, $urandom | 32'd1);
      lat = 0;
      bc = int'(busy);
      nI = int'($urandom_range(0, k));
      for (int i = 0; i < nI; i++) begin
        A = 2'($urandom_range(0, 3)); WE = 1'b1; WD = $urandom;
        step();
        WE = 1'b0;
        lat++;
        bc += int'(busy);
      end
      waitDone(lat, bc);
      chk("rand_lat", lat, 32'(k + 1));
      chk("rand_busy", bc, 32'(k));
      rdChk("rand_res", 2'd3, res);
      rdChk("rand_stat", 2'd2, {29'd0, e, 1'b0, 1'b1});
      repeat ($urandom_range(0, 3)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
